// File: rtl/sobel_stream.sv
`default_nettype none
// ============================================================================
// sobel_stream : streaming 3x3 Sobel edge detector, valid/ready in and out
// Revision 1.0 : initial release
// ============================================================================
module sobel_stream #(
    parameter int PIXEL_W = 8,
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 48
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [PIXEL_W-1:0] pixel_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [1:0]         mode_i,
    input  logic [PIXEL_W-1:0] thresh_i,
    output logic [PIXEL_W-1:0] pixel_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               eol_o,
    output logic               eof_o
);
    localparam int GW = PIXEL_W + 3;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0]      COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]      ROW_LAST = RW'(IMG_H - 1);
    localparam logic [PIXEL_W-1:0] PIX_MAX  = '1;

    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [1:0]         mode_q;
    logic [PIXEL_W-1:0] thresh_q;
    logic               valid_q, valid_d, eol_q, eol_d, eof_q, eof_d;
    logic [PIXEL_W-1:0] pix_q, pix_d;

    logic [PIXEL_W-1:0] lb_mid_q [IMG_W];
    logic [PIXEL_W-1:0] lb_top_q [IMG_W];
    // Two most recent window columns; the third column is the incoming one.
    logic [1:0][PIXEL_W-1:0] win_top_q, win_mid_q, win_bot_q;

    logic                      xfer, emit;
    logic [PIXEL_W-1:0]        top_new, mid_new;
    logic signed [GW-1:0]      gx, gy;
    logic [GW-1:0]             ax, ay, l1, sel_val;
    logic [PIXEL_W-1:0]        sat_sel, sat_l1, result;

    function automatic logic signed [GW-1:0] ext(input logic [PIXEL_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    function automatic logic [PIXEL_W-1:0] sat(input logic [GW-1:0] v);
        return (v > {3'b000, PIX_MAX}) ? PIX_MAX : v[PIXEL_W-1:0];
    endfunction

    assign ready_o = !valid_q || ready_i;
    assign xfer    = valid_i && ready_o;
    assign emit    = xfer && (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign top_new = lb_top_q[col_q];
    assign mid_new = lb_mid_q[col_q];

    // p0..p8 row-major: columns [0],[1] from the window, column 2 from the buffers/input.
    assign gx = (ext(top_new) - ext(win_top_q[0]))
              + ((ext(mid_new) - ext(win_mid_q[0])) <<< 1)
              + (ext(pixel_i) - ext(win_bot_q[0]));
    assign gy = (ext(win_bot_q[0]) - ext(win_top_q[0]))
              + ((ext(win_bot_q[1]) - ext(win_top_q[1])) <<< 1)
              + (ext(pixel_i) - ext(top_new));
    assign ax = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    assign ay = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    assign l1 = ax + ay;

    always_comb begin
        sel_val = l1;
        case (mode_q)
            2'b01:   sel_val = ax;
            2'b10:   sel_val = ay;
            default: sel_val = l1;
        endcase
        sat_sel = sat(sel_val);
        sat_l1  = sat(l1);
        result  = sat_sel;
        if (mode_q == 2'b11) begin
            result = (sat_l1 >= thresh_q) ? PIX_MAX : '0;
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (xfer) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        pix_d   = pix_q;
        eol_d   = eol_q;
        eof_d   = eof_q;
        if (emit) begin
            valid_d = 1'b1;
            pix_d   = result;
            eol_d   = (col_q == COL_LAST);
            eof_d   = (col_q == COL_LAST) && (row_q == ROW_LAST);
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q    <= '0;
            row_q    <= '0;
            mode_q   <= 2'b00;
            thresh_q <= '0;
            valid_q  <= 1'b0;
            pix_q    <= '0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            pix_q   <= pix_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            if (xfer && (col_q == '0) && (row_q == '0)) begin
                mode_q   <= mode_i;
                thresh_q <= thresh_i;
            end
        end
    end

    // Pixel storage is never reset: rows 0 and 1 refill it before any output uses it.
    always_ff @(posedge clk_i) begin
        if (xfer) begin
            lb_top_q[col_q] <= mid_new;
            lb_mid_q[col_q] <= pixel_i;
            win_top_q       <= {top_new, win_top_q[1]};
            win_mid_q       <= {mid_new, win_mid_q[1]};
            win_bot_q       <= {pixel_i, win_bot_q[1]};
        end
    end

    assign pixel_o = pix_q;
    assign valid_o = valid_q;
    assign eol_o   = eol_q;
    assign eof_o   = eof_q;
endmodule
`default_nettype wire

// File: tb/tb_sobel_stream.sv
`default_nettype none
// ============================================================================
// tb_sobel_stream : directed bench for sobel_stream (8-bit 8x6, 10-bit 4x3)
// Revision 1.0 : initial release
// ============================================================================
module tb_sobel_stream;
    localparam int W = 8, H = 6, OW = 6, NOUT = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pixel_i, thresh_i, pixel_o;
    logic [1:0] mode_i;
    logic       valid_i, ready_o, valid_o, ready_i, eol_o, eof_o;

    logic [9:0] p10_i, th10_i, p10_o;
    logic [1:0] mode10_i;
    logic       v10_i, rdy10_o, vo10_o, eol10_o, eof10_o;
    logic       rdy10_i = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    logic rand_rdy = 1'b0;
    logic stall_chk = 1'b0;
    int img [H][W];
    int exp_pix [NOUT];
    int base = 0;
    int base10 = 0;

    logic [9:0]  cap_q [$];
    logic [11:0] cap10_q [$];
    logic [21:0] stall_q [$];
    logic        was_stall = 1'b0;
    logic [10:0] held = '0;

    always #5 clk = ~clk;

    sobel_stream #(.PIXEL_W(8), .IMG_W(W), .IMG_H(H)) u_dut (
        .clk_i(clk), .rst_i(rst), .pixel_i(pixel_i), .valid_i(valid_i),
        .ready_o(ready_o), .mode_i(mode_i), .thresh_i(thresh_i),
        .pixel_o(pixel_o), .valid_o(valid_o), .ready_i(ready_i),
        .eol_o(eol_o), .eof_o(eof_o)
    );

    sobel_stream #(.PIXEL_W(10), .IMG_W(4), .IMG_H(3)) u_dut10 (
        .clk_i(clk), .rst_i(rst), .pixel_i(p10_i), .valid_i(v10_i),
        .ready_o(rdy10_o), .mode_i(mode10_i), .thresh_i(th10_i),
        .pixel_o(p10_o), .valid_o(vo10_o), .ready_i(rdy10_i),
        .eol_o(eol10_o), .eof_o(eof10_o)
    );

    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output capture at the falling edge, where handshake signals are settled.
    always @(negedge clk) begin
        if (rst) begin
            was_stall = 1'b0;
        end else begin
            if (was_stall && stall_chk)
                stall_q.push_back({held, valid_o, pixel_o, eol_o, eof_o});
            if (valid_o && ready_i)
                cap_q.push_back({pixel_o, eol_o, eof_o});
            was_stall = valid_o && !ready_i;
            held      = {valid_o, pixel_o, eol_o, eof_o};
            if (vo10_o)
                cap10_q.push_back({p10_o, eol10_o, eof10_o});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic send_pix(input logic [7:0] p);
        bit done;
        done    = 1'b0;
        pixel_i = p;
        valid_i = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            done = ready_o;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $error("FAIL send_timeout: observed ready_o 0 expected 1");
        end
    endtask

    task automatic send_frame(input int chg_idx, input logic [7:0] chg_th);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r * W + c == chg_idx) thresh_i = chg_th;
                send_pix(8'(img[r][c]));
            end
        end
        valid_i = 1'b0;
    endtask

    function automatic int golden(int r, int c, int mode, int th);
        int gx, gy, ax, ay, l1, s;
        gx = (img[r-1][c+1] - img[r-1][c-1]) + 2 * (img[r][c+1] - img[r][c-1])
           + (img[r+1][c+1] - img[r+1][c-1]);
        gy = (img[r+1][c-1] - img[r-1][c-1]) + 2 * (img[r+1][c] - img[r-1][c])
           + (img[r+1][c+1] - img[r-1][c+1]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        l1 = ax + ay;
        case (mode)
            1:       s = ax;
            2:       s = ay;
            default: s = l1;
        endcase
        if (s > 255) s = 255;
        if (mode == 3) s = (s >= th) ? 255 : 0;
        return s;
    endfunction

    task automatic check_frame(input string tag);
        logic [9:0] e;
        int r, c;
        for (int k = 0; k < 400 && (cap_q.size() - base) < NOUT; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk($sformatf("%s_count", tag), cap_q.size() - base, NOUT);
        for (int i = 0; i < NOUT && base + i < cap_q.size(); i++) begin
            r = i / OW + 1;
            c = i % OW + 1;
            e = cap_q[base + i];
            chk($sformatf("%s_pix%0d", tag, i), e[9:2], exp_pix[i]);
            chk($sformatf("%s_eol%0d", tag, i), e[1], (c == W - 2));
            chk($sformatf("%s_eof%0d", tag, i), e[0], (c == W - 2) && (r == H - 2));
        end
        base = cap_q.size();
    endtask

    task automatic send10_frame(input logic [1:0] m);
        mode10_i = m;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                p10_i = (r + c >= 2) ? 10'd1023 : 10'd0;
                v10_i = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        v10_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] th;
        rst = 1'b1; valid_i = 1'b0; pixel_i = '0; mode_i = 2'b00; thresh_i = '0;
        v10_i = 1'b0; p10_i = '0; mode10_i = 2'b00; th10_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_valid_o", valid_o, 1'b0);
        chk("rst_ready_o", ready_o, 1'b1);
        chk("rst_pixel_o", pixel_o, 8'd0);
        chk("rst_eol_o", eol_o, 1'b0);
        chk("rst_eof_o", eof_o, 1'b0);
        chk("rst_valid10_o", vo10_o, 1'b0);

        // Flat field: no gradient anywhere.
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 100;
        mode_i = 2'b00;
        for (int i = 0; i < NOUT; i++) exp_pix[i] = 0;
        send_frame(-1, 8'd0);
        check_frame("flat");

        // Vertical step between columns 3 and 4: |Gx| = 1020 saturates at centre cols 3,4.
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c >= 4) ? 255 : 0;
        mode_i = 2'b01;
        for (int i = 0; i < NOUT; i++) exp_pix[i] = ((i % OW + 1 == 3) || (i % OW + 1 == 4)) ? 255 : 0;
        send_frame(-1, 8'd0);
        check_frame("step_gx");

        mode_i = 2'b10;
        for (int i = 0; i < NOUT; i++) exp_pix[i] = 0;
        send_frame(-1, 8'd0);
        check_frame("step_gy");

        // Threshold 200, dropped to 0 mid-frame: the frame still uses 200.
        mode_i   = 2'b11;
        thresh_i = 8'd200;
        for (int i = 0; i < NOUT; i++) exp_pix[i] = ((i % OW + 1 == 3) || (i % OW + 1 == 4)) ? 255 : 0;
        send_frame(24, 8'd0);
        check_frame("thr_200");

        // Threshold 0 now takes effect: every output passes.
        for (int i = 0; i < NOUT; i++) exp_pix[i] = 255;
        send_frame(-1, 8'd0);
        check_frame("thr_0");

        // Random pixels with random downstream stalls, one frame per mode.
        rand_rdy  = 1'b1;
        stall_chk = 1'b1;
        for (int m = 0; m < 4; m++) begin
            for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 255);
            th       = 8'($urandom_range(0, 255));
            mode_i   = 2'(m);
            thresh_i = th;
            for (int i = 0; i < NOUT; i++) exp_pix[i] = golden(i / OW + 1, i % OW + 1, m, int'(th));
            send_frame(-1, 8'd0);
            check_frame($sformatf("rand_m%0d", m));
        end
        rand_rdy  = 1'b0;
        stall_chk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("stall_seen", stall_q.size() > 0, 1'b1);
        for (int i = 0; i < stall_q.size(); i++)
            chk($sformatf("stall_hold%0d", i), stall_q[i][10:0], stall_q[i][21:11]);

        // Reset for one cycle where pixel (3,5) would transfer.
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 255);
        mode_i = 2'b00;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < W; c++)
                if (r < 3 || c < 5) send_pix(8'(img[r][c]));
        rst     = 1'b1;
        pixel_i = 8'd0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        valid_i = 1'b0;
        chk("midrst_valid_o", valid_o, 1'b0);
        chk("midrst_ready_o", ready_o, 1'b1);
        @(posedge clk);
        #1;
        base = cap_q.size();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 255);
        for (int i = 0; i < NOUT; i++) exp_pix[i] = golden(i / OW + 1, i % OW + 1, 0, 0);
        send_frame(-1, 8'd0);
        check_frame("post_rst");

        // 10-bit, minimum-size 4x3 frame: L1 = 6138 and 2046 both clamp to 1023.
        chk("w10_ready_o", rdy10_o, 1'b1);
        send10_frame(2'b00);
        chk("w10_l1_count", cap10_q.size() - base10, 2);
        if (cap10_q.size() >= base10 + 2) begin
            chk("w10_l1_pix0", cap10_q[base10][11:2], 10'd1023);
            chk("w10_l1_eol0", cap10_q[base10][1:0], 2'b00);
            chk("w10_l1_pix1", cap10_q[base10 + 1][11:2], 10'd1023);
            chk("w10_l1_eol1", cap10_q[base10 + 1][1:0], 2'b11);
        end
        base10 = cap10_q.size();
        // |Gx| = 3069 and 1023.
        send10_frame(2'b01);
        chk("w10_gx_count", cap10_q.size() - base10, 2);
        if (cap10_q.size() >= base10 + 2) begin
            chk("w10_gx_pix0", cap10_q[base10][11:2], 10'd1023);
            chk("w10_gx_pix1", cap10_q[base10 + 1][11:2], 10'd1023);
            chk("w10_gx_eof1", cap10_q[base10 + 1][0], 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
